// File: rtl/pe_feeder.sv
// pe_feeder: head-of-array feeder for the Smith-Waterman systolic PE chain.
// Buffers one target sequence (2-bit bases) from a valid/ready stream, then
// plays it into PE[0] one base per clock with no bubbles. The chain cannot
// stall, so playback only starts once the whole sequence is buffered.
// Optional feature: define GLOBAL_ALIGN_EN for a global-alignment row-0
// boundary (affine gap ramp on pe_v). Without it, the boundary is all zero
// (local alignment) and the accumulator logic is not built.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_FILL   | accepting bases into the buffer, waiting for in_last
// S_DROP   | overflowed; discarding beats up to and including in_last
// S_STREAM | entry cycle, then one buffered base per cycle to PE[0]
// S_GAP    | one idle cycle between sequences, then back to S_FILL
module pe_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_in_t,
  input  logic              i_in_last,
  input  logic [DATA_W-1:0] i_minus_alpha,
  input  logic [DATA_W-1:0] i_minus_beta,
  output logic              o_pe_newline,
  output logic [1:0]        o_pe_t,
  output logic [DATA_W-1:0] o_pe_v,
  output logic [DATA_W-1:0] o_pe_v_alpha,
  output logic [DATA_W-1:0] o_pe_f,
  output logic              o_pe_valid,
  output logic [CNT_W-1:0]  o_seq_len,
  output logic              o_err_overflow
);

  localparam int              ADDR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_DROP   = 2'd1,
    S_STREAM = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_seq_len;
  logic              r_in_ready;
  logic              r_err_overflow;
  logic              r_pe_valid;
  logic              r_pe_newline;
  logic [1:0]        r_pe_t;

  logic              w_accept;
  logic              w_fill_accept;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_full;
  logic              w_load;
  logic              w_enter_stream;
  logic              w_overflow;

  assign w_accept      = r_in_ready & i_in_valid;
  assign w_fill_accept = w_accept && (r_state == S_FILL);
  assign w_count_inc   = r_count + CNT_W'(1);
  assign w_full        = (w_count_inc == DEPTH_C);
  // The STREAM entry cycle has rd_ptr==0 and nothing shown yet; the cycle in
  // which rd_ptr reaches seq_len is the one that shows the final base.
  assign w_load        = (r_state == S_STREAM) && (r_rd_ptr != r_seq_len);

  // Next-state decode and the one-cycle events that steer the datapath.
  always_comb begin
    w_state_nxt    = r_state;
    w_enter_stream = 1'b0;
    w_overflow     = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (i_in_last) begin
            w_state_nxt    = S_STREAM;
            w_enter_stream = 1'b1;
          end else if (w_full) begin
            w_state_nxt = S_DROP;
            w_overflow  = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (w_accept && i_in_last) begin
          w_state_nxt = S_FILL;
        end
      end
      S_STREAM: begin
        if (!w_load) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_state_nxt = S_FILL;
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // State register, fill counter, playback pointer and registered PE outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_FILL;
      r_in_ready     <= 1'b0;
      r_count        <= '0;
      r_rd_ptr       <= '0;
      r_seq_len      <= '0;
      r_err_overflow <= 1'b0;
      r_pe_valid     <= 1'b0;
      r_pe_newline   <= 1'b0;
      r_pe_t         <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      // Ready is registered from the next state so it drops in the very
      // cycle after the in_last handshake.
      r_in_ready <= (w_state_nxt == S_FILL) || (w_state_nxt == S_DROP);

      if (w_fill_accept) begin
        if (w_enter_stream || w_overflow) begin
          r_count <= '0;
        end else begin
          r_count <= w_count_inc;
        end
      end

      if (w_enter_stream) begin
        r_seq_len <= w_count_inc;
        r_rd_ptr  <= '0;
      end else if (w_load) begin
        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      end

      if (w_overflow) begin
        r_err_overflow <= 1'b1;
      end

      r_pe_valid   <= w_load;
      r_pe_newline <= w_load && (r_rd_ptr == '0);
      r_pe_t       <= w_load ? r_mem[r_rd_ptr[ADDR_W-1:0]] : 2'd0;
    end
  end

  // Base storage; contents need no reset because count/seq_len gate use.
  always_ff @(posedge i_clk) begin
    if (w_fill_accept) begin
      r_mem[r_count[ADDR_W-1:0]] <= i_in_t;
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_pe_valid     = r_pe_valid;
  assign o_pe_newline   = r_pe_newline;
  assign o_pe_t         = r_pe_t;
  assign o_seq_len      = r_seq_len;
  assign o_err_overflow = r_err_overflow;

`ifdef GLOBAL_ALIGN_EN
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};

  // Two's complement add that clamps instead of wrapping.
  function automatic logic [DATA_W-1:0] f_sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? SMIN : SMAX;
    end
    return s[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] r_alpha;
  logic [DATA_W-1:0] r_beta;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_pe_v;
  logic [DATA_W-1:0] r_pe_v_alpha;
  logic [DATA_W-1:0] r_pe_f;

  // Row-0 gap ramp: acc starts at alpha and steps by beta per base, so base
  // j sees alpha + (j-1)*beta; penalties are frozen at STREAM entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alpha      <= '0;
      r_beta       <= '0;
      r_acc        <= '0;
      r_pe_v       <= '0;
      r_pe_v_alpha <= '0;
      r_pe_f       <= '0;
    end else begin
      if (w_enter_stream) begin
        r_alpha <= i_minus_alpha;
        r_beta  <= i_minus_beta;
        r_acc   <= i_minus_alpha;
      end else if (w_load) begin
        r_acc <= f_sat_add(r_acc, r_beta);
      end
      if (w_load) begin
        r_pe_v       <= r_acc;
        r_pe_v_alpha <= f_sat_add(r_acc, r_alpha);
        r_pe_f       <= SMIN;
      end else begin
        r_pe_v       <= '0;
        r_pe_v_alpha <= '0;
        r_pe_f       <= '0;
      end
    end
  end

  assign o_pe_v       = r_pe_v;
  assign o_pe_v_alpha = r_pe_v_alpha;
  assign o_pe_f       = r_pe_f;
`else
  // Local alignment: zero floor on the row-0 boundary, penalties not needed.
  logic w_unused_penalties;
  assign w_unused_penalties = ^{i_minus_alpha, i_minus_beta};

  assign o_pe_v       = '0;
  assign o_pe_v_alpha = '0;
  assign o_pe_f       = '0;
`endif

endmodule
